// File: rtl/cache_assoc_ctrl_if.sv
// Signal bundle between the set-associative cache controller and its processor/datapath environment.
// master = controller side, slave = processor port plus tag/data arrays and batch engine.
interface cache_assoc_ctrl_if #(
    parameter int p_num_ways = 2,
    parameter int p_num_sets = 8
);
    localparam int WAYW = $clog2(p_num_ways);
    localparam int IDXW = $clog2(p_num_sets);

    logic                  memreq_val;
    logic                  memreq_rdy;
    logic                  memreq_type;
    logic [IDXW-1:0]       memreq_idx;
    logic                  req_reg_en;
    logic                  memresp_val;
    logic                  memresp_rdy;
    logic [p_num_ways-1:0] tag_match;
    logic [p_num_ways-1:0] way_valid;
    logic [p_num_ways-1:0] way_dirty;
    logic [WAYW-1:0]       way_sel;
    logic                  idx_sel;
    logic [IDXW-1:0]       flush_idx;
    logic                  darray_wen;
    logic                  darray_fill_sel;
    logic                  tarray_wen;
    logic                  valid_wen;
    logic                  dirty_wen;
    logic                  dirty_wdata;
    logic                  batch_val;
    logic                  batch_rdy;
    logic                  batch_rw;
    logic                  batch_done;
    logic                  flush_val;
    logic                  flush_rdy;
    logic                  flush_done;

    modport master (
        input  memreq_val, memreq_type, memreq_idx, memresp_rdy,
        input  tag_match, way_valid, way_dirty, batch_rdy, batch_done, flush_val,
        output memreq_rdy, req_reg_en, memresp_val, way_sel, idx_sel, flush_idx,
        output darray_wen, darray_fill_sel, tarray_wen, valid_wen, dirty_wen, dirty_wdata,
        output batch_val, batch_rw, flush_rdy, flush_done
    );

    modport slave (
        output memreq_val, memreq_type, memreq_idx, memresp_rdy,
        output tag_match, way_valid, way_dirty, batch_rdy, batch_done, flush_val,
        input  memreq_rdy, req_reg_en, memresp_val, way_sel, idx_sel, flush_idx,
        input  darray_wen, darray_fill_sel, tarray_wen, valid_wen, dirty_wen, dirty_wdata,
        input  batch_val, batch_rw, flush_rdy, flush_done
    );
endinterface

// File: rtl/cache_assoc_ctrl.sv
// Write-back, write-allocate N-way set-associative cache controller: lookup, victim eviction, refill, flush.
// Define CACHE_ASSOC_LRU_EN for true-LRU replacement; default build uses per-set round-robin pointers.
module cache_assoc_ctrl #(
    parameter int p_num_ways = 2,
    parameter int p_num_sets = 8
) (
    input logic                clk,
    input logic                reset,
    cache_assoc_ctrl_if.master bus
);
    localparam int WAYW = $clog2(p_num_ways);
    localparam int IDXW = $clog2(p_num_sets);

    // state | meaning: IDLE accept | TAG lookup | EVICT(_WAIT) write back victim | REFILL(_WAIT) read line
    // FILL install line | RESP hold response | FLUSH(_WAIT) scan/write dirty entries | FLUSH_DONE completion pulse
    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_TAG         = 4'd1;
    localparam logic [3:0] S_EVICT       = 4'd2;
    localparam logic [3:0] S_EVICT_WAIT  = 4'd3;
    localparam logic [3:0] S_REFILL      = 4'd4;
    localparam logic [3:0] S_REFILL_WAIT = 4'd5;
    localparam logic [3:0] S_FILL        = 4'd6;
    localparam logic [3:0] S_RESP        = 4'd7;
    localparam logic [3:0] S_FLUSH       = 4'd8;
    localparam logic [3:0] S_FLUSH_WAIT  = 4'd9;
    localparam logic [3:0] S_FLUSH_DONE  = 4'd10;

    logic [3:0]      r_state;
    logic [3:0]      w_state_nxt;
    logic            r_type;
    logic [IDXW-1:0] r_idx;
    logic [IDXW-1:0] r_flush_idx;
    logic [WAYW-1:0] r_victim;
    logic [WAYW-1:0] r_flush_way;

    logic            w_hit;
    logic            w_inv_found;
    logic [WAYW-1:0] w_hit_way;
    logic [WAYW-1:0] w_inv_way;
    logic [WAYW-1:0] w_repl_way;
    logic [WAYW-1:0] w_victim;
    logic            w_flush_adv;
    logic            w_flush_last;

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = p_num_ways - 1; i >= 0; i--) begin
            if (bus.tag_match[i]) w_hit_way = WAYW'(i);
            if (!bus.way_valid[i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAYW'(i);
            end
        end
    end

    assign w_hit        = |bus.tag_match;
    assign w_victim     = w_inv_found ? w_inv_way : w_repl_way;
    assign w_flush_last = (r_flush_idx == IDXW'(p_num_sets - 1)) && (r_flush_way == WAYW'(p_num_ways - 1));
    assign bus.flush_idx = r_flush_idx;

`ifdef CACHE_ASSOC_LRU_EN
    logic [WAYW-1:0] r_age [p_num_sets][p_num_ways];
    logic            w_touch;
    logic [WAYW-1:0] w_touch_way;

    assign w_touch     = ((r_state == S_TAG) && w_hit) || (r_state == S_FILL);
    assign w_touch_way = (r_state == S_FILL) ? r_victim : w_hit_way;

    always_comb begin
        w_repl_way = '0;
        for (int i = 0; i < p_num_ways; i++) begin
            if (r_age[r_idx][i] == WAYW'(p_num_ways - 1)) w_repl_way = WAYW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < p_num_sets; s++) begin
                for (int w = 0; w < p_num_ways; w++) begin
                    r_age[s][w] <= WAYW'(w);
                end
            end
        end else if (w_touch) begin
            for (int w = 0; w < p_num_ways; w++) begin
                if (WAYW'(w) == w_touch_way) begin
                    r_age[r_idx][w] <= '0;
                end else if (r_age[r_idx][w] < r_age[r_idx][w_touch_way]) begin
                    r_age[r_idx][w] <= r_age[r_idx][w] + 1'b1;
                end
            end
        end
    end
`else
    logic [WAYW-1:0] r_rr_ptr [p_num_sets];

    assign w_repl_way = r_rr_ptr[r_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < p_num_sets; s++) begin
                r_rr_ptr[s] <= '0;
            end
        end else if (r_state == S_FILL) begin
            r_rr_ptr[r_idx] <= r_rr_ptr[r_idx] + 1'b1;
        end
    end
`endif

    // Outputs are forced low while reset is asserted.
    always_comb begin
        w_state_nxt         = r_state;
        w_flush_adv         = 1'b0;
        bus.memreq_rdy      = 1'b0;
        bus.req_reg_en      = 1'b0;
        bus.memresp_val     = 1'b0;
        bus.way_sel         = '0;
        bus.idx_sel         = 1'b0;
        bus.darray_wen      = 1'b0;
        bus.darray_fill_sel = 1'b0;
        bus.tarray_wen      = 1'b0;
        bus.valid_wen       = 1'b0;
        bus.dirty_wen       = 1'b0;
        bus.dirty_wdata     = 1'b0;
        bus.batch_val       = 1'b0;
        bus.batch_rw        = 1'b0;
        bus.flush_rdy       = 1'b0;
        bus.flush_done      = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    bus.flush_rdy  = 1'b1;
                    bus.memreq_rdy = !bus.flush_val;
                    if (bus.flush_val) begin
                        w_state_nxt = S_FLUSH;
                    end else if (bus.memreq_val) begin
                        bus.req_reg_en = 1'b1;
                        w_state_nxt    = S_TAG;
                    end
                end
                S_TAG: begin
                    if (w_hit) begin
                        bus.way_sel     = w_hit_way;
                        bus.memresp_val = 1'b1;
                        if (r_type) begin
                            bus.darray_wen  = 1'b1;
                            bus.dirty_wen   = 1'b1;
                            bus.dirty_wdata = 1'b1;
                        end
                        w_state_nxt = bus.memresp_rdy ? S_IDLE : S_RESP;
                    end else begin
                        bus.way_sel = w_victim;
                        w_state_nxt = bus.way_dirty[w_victim] ? S_EVICT : S_REFILL;
                    end
                end
                S_EVICT: begin
                    bus.way_sel   = r_victim;
                    bus.batch_val = 1'b1;
                    bus.batch_rw  = 1'b1;
                    if (bus.batch_rdy) w_state_nxt = S_EVICT_WAIT;
                end
                S_EVICT_WAIT: begin
                    bus.way_sel = r_victim;
                    if (bus.batch_done) w_state_nxt = S_REFILL;
                end
                S_REFILL: begin
                    bus.way_sel   = r_victim;
                    bus.batch_val = 1'b1;
                    if (bus.batch_rdy) w_state_nxt = S_REFILL_WAIT;
                end
                S_REFILL_WAIT: begin
                    bus.way_sel = r_victim;
                    if (bus.batch_done) w_state_nxt = S_FILL;
                end
                S_FILL: begin
                    bus.way_sel         = r_victim;
                    bus.tarray_wen      = 1'b1;
                    bus.valid_wen       = 1'b1;
                    bus.darray_wen      = 1'b1;
                    bus.darray_fill_sel = 1'b1;
                    bus.dirty_wen       = 1'b1;
                    w_state_nxt         = S_TAG;
                end
                S_RESP: begin
                    bus.memresp_val = 1'b1;
                    if (bus.memresp_rdy) w_state_nxt = S_IDLE;
                end
                S_FLUSH: begin
                    bus.idx_sel = 1'b1;
                    bus.way_sel = r_flush_way;
                    if (bus.way_valid[r_flush_way] && bus.way_dirty[r_flush_way]) begin
                        bus.batch_val = 1'b1;
                        bus.batch_rw  = 1'b1;
                        if (bus.batch_rdy) w_state_nxt = S_FLUSH_WAIT;
                    end else begin
                        w_flush_adv = 1'b1;
                    end
                end
                S_FLUSH_WAIT: begin
                    bus.idx_sel = 1'b1;
                    bus.way_sel = r_flush_way;
                    if (bus.batch_done) begin
                        bus.dirty_wen = 1'b1;
                        w_flush_adv   = 1'b1;
                        w_state_nxt   = S_FLUSH;
                    end
                end
                S_FLUSH_DONE: begin
                    bus.flush_done = 1'b1;
                    w_state_nxt    = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
            if (w_flush_adv && w_flush_last) w_state_nxt = S_FLUSH_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_type      <= 1'b0;
            r_idx       <= '0;
            r_victim    <= '0;
            r_flush_idx <= '0;
            r_flush_way <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.req_reg_en) begin
                r_type <= bus.memreq_type;
                r_idx  <= bus.memreq_idx;
            end
            if ((r_state == S_TAG) && !w_hit) r_victim <= w_victim;
            if (r_state == S_FLUSH_DONE) begin
                r_flush_idx <= '0;
                r_flush_way <= '0;
            end else if (w_flush_adv && !w_flush_last) begin
                r_flush_way <= r_flush_way + 1'b1;
                if (r_flush_way == WAYW'(p_num_ways - 1)) r_flush_idx <= r_flush_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed bench for cache_assoc_ctrl: 2-way instance for handshake, miss, flush and reset sequences,
// 4-way instance for replacement-victim selection.
`timescale 1ns/1ps
module tb_cache_assoc_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_assoc_ctrl_if #(.p_num_ways(2), .p_num_sets(8)) b2 ();
    cache_assoc_ctrl_if #(.p_num_ways(4), .p_num_sets(8)) b4 ();

    cache_assoc_ctrl #(.p_num_ways(2), .p_num_sets(8)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));
    cache_assoc_ctrl #(.p_num_ways(4), .p_num_sets(8)) u_dut4 (.clk(clk), .reset(reset), .bus(b4));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       typ;
        logic [2:0] idx;
        logic [1:0] tm;
        logic [1:0] vv;
        logic [1:0] dd;
        logic       rrdy;
        logic       exp_resp;
        int         exp_way;
        logic       exp_dwen;
        int         exp_nxt;   // 0 IDLE, 1 EVICT, 2 REFILL, 3 RESP
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue2(input logic typ, input logic [2:0] idx, input string name);
        b2.memreq_val  = 1'b1;
        b2.memreq_type = typ;
        b2.memreq_idx  = idx;
        #1;
        chk({name, " accept"}, int'(b2.req_reg_en), 1);
        cyc();
        b2.memreq_val = 1'b0;
    endtask

    // Entered in EVICT (evict=1) or REFILL (evict=0) with batch_rdy high; runs the miss to IDLE.
    task automatic finish_miss2(input int victim, input logic evict, input string name);
        if (evict) begin
            cyc();
            b2.batch_done = 1'b1;
            cyc();
            b2.batch_done = 1'b0;
        end
        cyc();
        b2.batch_done = 1'b1;
        cyc();
        b2.batch_done = 1'b0;
        #1;
        chk({name, " fill tarray_wen"}, int'(b2.tarray_wen), 1);
        chk({name, " fill way_sel"}, int'(b2.way_sel), victim);
        cyc();
        b2.tag_match   = 2'(1 << victim);
        b2.way_valid   = 2'b11;
        b2.memresp_rdy = 1'b1;
        #1;
        chk({name, " second tag resp"}, int'(b2.memresp_val), 1);
        cyc();
        b2.tag_match = 2'b00;
        #1;
        chk({name, " back idle"}, int'(b2.memreq_rdy), 1);
    endtask

    task automatic miss4(input logic [3:0] vv, input int exp_victim, input string name);
        int v;
        b4.memreq_val  = 1'b1;
        b4.memreq_type = 1'b0;
        b4.memreq_idx  = 3'd3;
        cyc();
        b4.memreq_val = 1'b0;
        b4.tag_match  = 4'b0000;
        b4.way_valid  = vv;
        b4.way_dirty  = 4'b0000;
        cyc();
        #1;
        chk({name, " refill batch_val"}, int'(b4.batch_val), 1);
        chk({name, " victim"}, int'(b4.way_sel), exp_victim);
        v = int'(b4.way_sel);
        cyc();
        b4.batch_done = 1'b1;
        cyc();
        b4.batch_done = 1'b0;
        cyc();
        b4.tag_match   = 4'(1 << v);
        b4.way_valid   = vv | 4'(1 << v);
        b4.memresp_rdy = 1'b1;
        cyc();
        b4.tag_match = 4'b0000;
    endtask

    task automatic hit4(input int way, input string name);
        b4.memreq_val  = 1'b1;
        b4.memreq_type = 1'b0;
        b4.memreq_idx  = 3'd3;
        cyc();
        b4.memreq_val  = 1'b0;
        b4.tag_match   = 4'(1 << way);
        b4.way_valid   = 4'b1111;
        b4.memresp_rdy = 1'b1;
        #1;
        chk({name, " hit way"}, int'(b4.way_sel), way);
        cyc();
        b4.tag_match = 4'b0000;
    endtask

    function automatic int outs2();
        return int'({b2.memreq_rdy, b2.req_reg_en, b2.memresp_val, b2.way_sel, b2.idx_sel, b2.flush_idx,
                     b2.darray_wen, b2.darray_fill_sel, b2.tarray_wen, b2.valid_wen, b2.dirty_wen,
                     b2.dirty_wdata, b2.batch_val, b2.batch_rw, b2.flush_rdy, b2.flush_done});
    endfunction

    initial begin
        logic [1:0] vmask [8];
        logic [1:0] dmask [8];
        int nval, nwen, ndw, pend, nwr, nclr, done_at, bad_acc, bad_sel, exp_lru;

        vecs[0] = '{1'b0, 3'd2, 2'b10, 2'b11, 2'b00, 1'b1, 1'b1, 1, 1'b0, 0};
        vecs[1] = '{1'b1, 3'd4, 2'b01, 2'b11, 2'b00, 1'b1, 1'b1, 0, 1'b1, 0};
        vecs[2] = '{1'b1, 3'd6, 2'b10, 2'b11, 2'b00, 1'b0, 1'b1, 1, 1'b1, 3};
        vecs[3] = '{1'b0, 3'd1, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 1, 1'b0, 2};
        vecs[4] = '{1'b0, 3'd3, 2'b00, 2'b11, 2'b00, 1'b1, 1'b0, 1, 1'b0, 2};
        vecs[5] = '{1'b1, 3'd7, 2'b00, 2'b11, 2'b01, 1'b1, 1'b0, 0, 1'b0, 1};
        vecs[6] = '{1'b0, 3'd7, 2'b00, 2'b11, 2'b10, 1'b1, 1'b0, 1, 1'b0, 1};
        vecs[7] = '{1'b0, 3'd0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b0, 2};

        b2.memreq_val = 0; b2.memreq_type = 0; b2.memreq_idx = 0; b2.memresp_rdy = 1;
        b2.tag_match = 0; b2.way_valid = 0; b2.way_dirty = 0; b2.batch_rdy = 1;
        b2.batch_done = 0; b2.flush_val = 0;
        b4.memreq_val = 0; b4.memreq_type = 0; b4.memreq_idx = 0; b4.memresp_rdy = 1;
        b4.tag_match = 0; b4.way_valid = 0; b4.way_dirty = 0; b4.batch_rdy = 1;
        b4.batch_done = 0; b4.flush_val = 0;

        reset = 1'b1;
        repeat (3) cyc();
        chk("reset outputs zero", outs2(), 0);
        reset = 1'b0;
        #1;
        chk("post-reset memreq_rdy", int'(b2.memreq_rdy), 1);
        chk("post-reset flush_rdy", int'(b2.flush_rdy), 1);

        // Cold read of set 3: refill into way 0, response on the second TAG.
        issue2(1'b0, 3'd3, "cold");
        #1;
        chk("cold tag resp", int'(b2.memresp_val), 0);
        cyc();
        #1;
        chk("cold refill batch_val", int'(b2.batch_val), 1);
        chk("cold refill batch_rw", int'(b2.batch_rw), 0);
        chk("cold refill way_sel", int'(b2.way_sel), 0);
        cyc();
        #1;
        chk("cold refill_wait batch_val", int'(b2.batch_val), 0);
        b2.batch_done = 1'b1;
        cyc();
        b2.batch_done = 1'b0;
        #1;
        chk("cold fill valid_wen", int'(b2.valid_wen), 1);
        chk("cold fill fill_sel", int'(b2.darray_fill_sel), 1);
        chk("cold fill dirty_wen/wdata", int'({b2.dirty_wen, b2.dirty_wdata}), 2);
        cyc();
        b2.tag_match = 2'b01;
        b2.way_valid = 2'b01;
        #1;
        chk("cold second tag resp", int'(b2.memresp_val), 1);
        cyc();
        b2.tag_match = 2'b00;
        issue2(1'b0, 3'd3, "rehit");
        b2.tag_match = 2'b01;
        #1;
        chk("rehit resp next cycle", int'(b2.memresp_val), 1);
        chk("rehit no write", int'(b2.darray_wen), 0);
        cyc();
        b2.tag_match = 2'b00;

        for (int v = 0; v < 8; v++) begin
            issue2(vecs[v].typ, vecs[v].idx, $sformatf("vec%0d", v));
            b2.tag_match   = vecs[v].tm;
            b2.way_valid   = vecs[v].vv;
            b2.way_dirty   = vecs[v].dd;
            b2.memresp_rdy = vecs[v].rrdy;
            #1;
            chk($sformatf("vec%0d tag resp", v), int'(b2.memresp_val), int'(vecs[v].exp_resp));
            chk($sformatf("vec%0d tag darray_wen", v), int'(b2.darray_wen), int'(vecs[v].exp_dwen));
            chk($sformatf("vec%0d tag dirty_wen", v), int'(b2.dirty_wen), int'(vecs[v].exp_dwen));
            if (vecs[v].exp_resp) chk($sformatf("vec%0d hit way", v), int'(b2.way_sel), vecs[v].exp_way);
            cyc();
            b2.tag_match = 2'b00;
            #1;
            case (vecs[v].exp_nxt)
                0: chk($sformatf("vec%0d idle", v), int'(b2.memreq_rdy), 1);
                3: begin
                    chk($sformatf("vec%0d resp held", v), int'(b2.memresp_val), 1);
                    chk($sformatf("vec%0d resp no write", v), int'(b2.darray_wen | b2.dirty_wen), 0);
                    b2.memresp_rdy = 1'b1;
                    cyc();
                    #1;
                    chk($sformatf("vec%0d resp->idle", v), int'(b2.memreq_rdy), 1);
                end
                default: begin
                    chk($sformatf("vec%0d batch_val", v), int'(b2.batch_val), 1);
                    chk($sformatf("vec%0d batch_rw", v), int'(b2.batch_rw), (vecs[v].exp_nxt == 1) ? 1 : 0);
                    chk($sformatf("vec%0d victim", v), int'(b2.way_sel), vecs[v].exp_way);
                    finish_miss2(vecs[v].exp_way, vecs[v].exp_nxt == 1, $sformatf("vec%0d", v));
                end
            endcase
        end

        // Write hit on way 1, response stalled three cycles.
        issue2(1'b1, 3'd2, "whold");
        b2.tag_match = 2'b10; b2.way_valid = 2'b11; b2.way_dirty = 2'b00; b2.memresp_rdy = 1'b0;
        nval = 0; nwen = 0; ndw = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) b2.memresp_rdy = 1'b1;
            #1;
            nval += int'(b2.memresp_val);
            nwen += int'(b2.darray_wen);
            ndw  += int'(b2.dirty_wen);
            cyc();
        end
        b2.tag_match = 2'b00;
        chk("whold memresp_val cycles", nval, 4);
        chk("whold darray_wen pulses", nwen, 1);
        chk("whold dirty_wen pulses", ndw, 1);
        #1;
        chk("whold back idle", int'(b2.memreq_rdy), 1);

        // Set 5 full with way 0 dirty: eviction first, batch_rdy stalled two cycles.
        issue2(1'b0, 3'd5, "evict");
        b2.way_valid = 2'b11; b2.way_dirty = 2'b01; b2.batch_rdy = 1'b0;
        cyc();
        b2.batch_done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("evict stall%0d batch_val", k), int'(b2.batch_val), 1);
            chk($sformatf("evict stall%0d batch_rw", k), int'(b2.batch_rw), 1);
            chk($sformatf("evict stall%0d way_sel", k), int'(b2.way_sel), 0);
            cyc();
            b2.batch_done = 1'b0;
        end
        b2.batch_rdy = 1'b1;
        #1;
        chk("evict handshake batch_val", int'(b2.batch_val), 1);
        cyc();
        #1;
        chk("evict_wait batch_val", int'(b2.batch_val), 0);
        b2.batch_done = 1'b1;
        cyc();
        b2.batch_done = 1'b0;
        #1;
        chk("evict->refill batch_val", int'(b2.batch_val), 1);
        chk("evict->refill batch_rw", int'(b2.batch_rw), 0);
        finish_miss2(0, 1'b0, "evict");

        // Flush: valid+dirty at (2,w1) and (7,w1); (4,w0) dirty but invalid.
        for (int s = 0; s < 8; s++) begin
            vmask[s] = 2'b11;
            dmask[s] = 2'b00;
        end
        vmask[4] = 2'b10; dmask[4] = 2'b01;
        dmask[2] = 2'b10; dmask[7] = 2'b10;
        b2.flush_val = 1'b1; b2.memreq_val = 1'b1; b2.memreq_type = 1'b0; b2.memreq_idx = 3'd3;
        #1;
        chk("flush accept flush_rdy", int'(b2.flush_rdy), 1);
        chk("flush blocks memreq_rdy", int'(b2.memreq_rdy), 0);
        chk("flush blocks req_reg_en", int'(b2.req_reg_en), 0);
        cyc();
        b2.flush_val = 1'b0;
        pend = 0; nwr = 0; nclr = 0; done_at = -1; bad_acc = 0; bad_sel = 0;
        for (int k = 0; k < 60 && done_at < 0; k++) begin
            b2.batch_done = pend[0];
            b2.way_valid  = vmask[b2.flush_idx];
            b2.way_dirty  = dmask[b2.flush_idx];
            #1;
            if (b2.memreq_rdy || b2.req_reg_en) bad_acc++;
            if (!b2.idx_sel && !b2.flush_done) bad_sel++;
            if (b2.dirty_wen && !b2.dirty_wdata) begin
                dmask[b2.flush_idx][b2.way_sel] = 1'b0;
                nclr++;
            end
            pend = int'(b2.batch_val && b2.batch_rw);
            nwr += pend;
            if (b2.flush_done) done_at = k;
            else cyc();
        end
        b2.batch_done = 1'b0;
        chk("flush batch writes", nwr, 2);
        chk("flush dirty clears", nclr, 2);
        chk("flush_done cycle", done_at, 18);
        chk("flush memreq accepted early", bad_acc, 0);
        chk("flush idx_sel low", bad_sel, 0);
        chk("flush set2 dirty", int'(dmask[2]), 0);
        chk("flush set7 dirty", int'(dmask[7]), 0);
        chk("flush set4 untouched", int'(dmask[4]), 1);
        cyc();
        #1;
        chk("flush_done single pulse", int'(b2.flush_done), 0);
        chk("memreq accepted after flush", int'(b2.req_reg_en), 1);
        cyc();
        b2.memreq_val = 1'b0;
        b2.tag_match = 2'b01; b2.way_valid = 2'b11; b2.way_dirty = 2'b00; b2.memresp_rdy = 1'b1;
        cyc();
        b2.tag_match = 2'b00;

        // 4-way victim choice: fill ways 0..3 of set 3, touch 0,2,1, then miss with all ways valid.
        miss4(4'b0000, 0, "lru fill0");
        miss4(4'b0001, 1, "lru fill1");
        miss4(4'b0011, 2, "lru fill2");
        miss4(4'b0111, 3, "lru fill3");
        hit4(0, "touch0");
        hit4(2, "touch2");
        hit4(1, "touch1");
`ifdef CACHE_ASSOC_LRU_EN
        exp_lru = 3;
`else
        exp_lru = 0;
`endif
        miss4(4'b1111, exp_lru, "lru full miss");

        // Reset while waiting for a refill.
        issue2(1'b0, 3'd1, "rstmid");
        b2.way_valid = 2'b00; b2.way_dirty = 2'b00;
        cyc();
        cyc();
        #1;
        chk("rstmid refill_wait batch_val", int'(b2.batch_val), 0);
        reset = 1'b1;
        cyc();
        #1;
        chk("rstmid outputs zero", outs2(), 0);
        reset = 1'b0;
        #1;
        chk("rstmid idle memreq_rdy", int'(b2.memreq_rdy), 1);
        b2.batch_done = 1'b1;
        cyc();
        b2.batch_done = 1'b0;
        #1;
        chk("rstmid stray done no fill", int'(b2.tarray_wen | b2.valid_wen | b2.batch_val), 0);
        chk("rstmid still idle", int'(b2.memreq_rdy), 1);
        cyc();
        #1;
        chk("rstmid idle later", int'({b2.memreq_rdy, b2.tarray_wen}), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
